// File: rtl/smsdac_pkg.sv
// Shared types and constants for the segmented mismatch-shaping DAC encoder.
// The LFSR constants are only consumed when SMSDAC_DITHER_EN is defined.
package smsdac_pkg;

   // Per-layer shaper state, kept in {-1, 0, +1}.
   typedef logic signed [1:0] acc_t;

   localparam int unsigned LfsrWidth = 16;
   // Feedback taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
   localparam logic [LfsrWidth-1:0] LfsrTaps = 16'h002D;
   localparam logic [LfsrWidth-1:0] LfsrSeed = 16'hACE1;

   // Largest representable code for a B-layer encoder: two elements per layer.
   function automatic int unsigned max_code(input int unsigned b);
      return 2 * ((1 << b) - 1);
   endfunction

endpackage

// File: rtl/smsdac_layer.sv
// One weight layer of the encoder: greedy count extraction, element drive
// selection and the first-order shaper accumulator for that element pair.
module smsdac_layer
   import smsdac_pkg::*;
#(
   parameter int unsigned K = 0,   // layer index, weight 2^K
   parameter int unsigned W = 5    // residual width
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         shape_en,
   input  logic         tie,
   input  logic [W-1:0] res_in,
   output logic [1:0]   c,
   output logic         a,
   output logic         b,
   output logic [W-1:0] res_out
);

   acc_t         acc_q, acc_d;
   logic [W-1:0] q;

   // Greedy split: take up to two units of weight 2^K, pass the rest down.
   always_comb begin
      q       = res_in >> K;
      c       = (q >= W'(2)) ? 2'd2 : q[1:0];
      res_out = res_in - (W'(c) << K);
   end

   // Element selection and shaper next state.
   always_comb begin
      a     = 1'b0;
      b     = 1'b0;
      acc_d = acc_q;
      unique case (c)
         2'd2: begin
            a = 1'b1;
            b = 1'b1;
         end
         2'd1: begin
            if (!shape_en)             a = 1'b1;
            else if (acc_q > 2'sd0)    b = 1'b1;
            else if (acc_q < 2'sd0)    a = 1'b1;
            else if (tie)              b = 1'b1;
            else                       a = 1'b1;
         end
         default: ;
      endcase
      // s = a - b; the accumulator range is closed under the choice rule.
      if (!shape_en)       acc_d = '0;
      else if (a && !b)    acc_d = acc_q + 2'sd1;
      else if (b && !a)    acc_d = acc_q - 2'sd1;
   end

   // Accumulator advances only on sample strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   acc_q <= '0;
      else if (en)  acc_q <= acc_d;
   end

endmodule

// File: rtl/smsdac_seg_enc.sv
// Segmented mismatch-shaping DAC encoder top: input saturation, B chained
// layers (MSB to LSB), registered element drives and saturation flag.
// Define SMSDAC_DITHER_EN to add the LFSR tie-break dither.
module smsdac_seg_enc
   import smsdac_pkg::*;
#(
   parameter int unsigned B = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [B:0]   x,
   input  logic         en,
   input  logic         shape_en,
   output logic [B-1:0] elem_a,
   output logic [B-1:0] elem_b,
   output logic         sat
);

   localparam int unsigned W = B + 1;
   localparam logic [W-1:0] MaxCode = W'(max_code(B));

   logic         over;
   logic [W-1:0] xs;
   logic [W-1:0] res [B+1];
   logic [1:0]   c_v [B];
   logic [B-1:0] a_v, b_v, tie_v;

   // Clamp the input code to full scale.
   always_comb begin
      over = (x > MaxCode);
      xs   = over ? MaxCode : x;
   end

   assign res[B] = xs;

`ifdef SMSDAC_DITHER_EN
   logic [LfsrWidth-1:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR next state; the current value dithers this sample's ties.
   always_comb begin
      lfsr_d = {^(lfsr_q & LfsrTaps), lfsr_q[LfsrWidth-1:1]};
      tie_v  = lfsr_q[B-1:0];
   end

   // LFSR advances once per sample strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   lfsr_q <= LfsrSeed;
      else if (en)  lfsr_q <= lfsr_d;
   end
`else
   assign tie_v = '0;
`endif

   for (genvar k = 0; k < B; k++) begin : g_layer
      smsdac_layer #(
         .K (k),
         .W (W)
      ) u_layer (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en),
         .shape_en (shape_en),
         .tie      (tie_v[k]),
         .res_in   (res[k+1]),
         .c        (c_v[k]),
         .a        (a_v[k]),
         .b        (b_v[k]),
         .res_out  (res[k])
      );
   end

   // Output registers, held while en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_a <= '0;
         elem_b <= '0;
         sat    <= 1'b0;
      end else if (en) begin
         elem_a <= a_v;
         elem_b <= b_v;
         sat    <= over;
      end
   end

endmodule

// File: tb/tb_smsdac_seg_enc.sv
// Scoreboard bench for smsdac_seg_enc (B = 4): a behavioural model pushes
// expected samples, a monitor pops and compares after each clock edge.
module tb_smsdac_seg_enc;

   localparam int B    = 4;
   localparam int MAXC = 2 * ((1 << B) - 1);

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [B:0]   x = '0;
   logic         en = 1'b0;
   logic         shape_en = 1'b1;
   logic [B-1:0] elem_a, elem_b;
   logic         sat;

   typedef struct {
      logic [B-1:0] a;
      logic [B-1:0] b;
      logic         sat;
      int           xs;
      logic         shape;
   } exp_t;

   exp_t         q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           m_sum [B];
   logic [15:0]  m_lfsr = 16'hACE1;

   smsdac_seg_enc #(.B(B)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .x        (x),
      .en       (en),
      .shape_en (shape_en),
      .elem_a   (elem_a),
      .elem_b   (elem_b),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: clamp, greedy split by arithmetic, pick elements from the
   // running switching-sequence sum of each pair.
   task automatic model_step(input int xv, input bit sh);
      exp_t e;
      int   r, c;
      e.sat   = (xv > MAXC);
      e.xs    = (xv > MAXC) ? MAXC : xv;
      e.shape = sh;
      e.a     = '0;
      e.b     = '0;
      r       = e.xs;
      for (int k = B - 1; k >= 0; k--) begin
         c = r / (1 << k);
         if (c > 2) c = 2;
         r = r - c * (1 << k);
         if (c == 2) begin
            e.a[k] = 1'b1;
            e.b[k] = 1'b1;
         end else if (c == 1) begin
            if (!sh || m_sum[k] < 0) e.a[k] = 1'b1;
            else if (m_sum[k] > 0)   e.b[k] = 1'b1;
`ifdef SMSDAC_DITHER_EN
            else if (m_lfsr[k])      e.b[k] = 1'b1;
`endif
            else                     e.a[k] = 1'b1;
            if (sh) m_sum[k] = m_sum[k] + (e.a[k] ? 1 : -1);
         end
         if (!sh) m_sum[k] = 0;
      end
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      q.push_back(e);
   endtask

   task automatic model_reset();
      for (int k = 0; k < B; k++) m_sum[k] = 0;
      m_lfsr = 16'hACE1;
   endtask

   task automatic drive(input int xv, input bit e, input bit sh);
      @(negedge clk);
      x        = (B+1)'(xv);
      en       = e;
      shape_en = sh;
      if (e) model_step(xv, sh);
   endtask

   // Mid-stream asynchronous reset pulse spanning one rising edge.
   task automatic reset_pulse();
      @(negedge clk);
      en    = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_reset_clear", {elem_a, elem_b, sat}, '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: compares each presented sample, and checks hold otherwise.
   initial begin : monitor
      logic [2*B:0] last;
      int           dut_sum [B];
      bit           seen;
      exp_t         e;
      int           dac, worst;
      last = '0;
      for (int k = 0; k < B; k++) dut_sum[k] = 0;
      forever begin
         @(posedge clk);
         seen = en && rst_n;
         #1;
         if (!rst_n) begin
            last = '0;
            for (int k = 0; k < B; k++) dut_sum[k] = 0;
         end
         if (!seen) begin
            check("hold_or_reset", {elem_a, elem_b, sat}, last);
         end else if (q.size() == 0) begin
            check("unexpected_sample", 1, 0);
         end else begin
            e = q.pop_front();
            check("elem_a_b_sat", {elem_a, elem_b, sat}, {e.a, e.b, e.sat});
            dac = 0;
            for (int k = 0; k < B; k++)
               dac += (int'(elem_a[k]) + int'(elem_b[k])) * (1 << k);
            check("dac_v_equals_xs", dac, e.xs);
            worst = 0;
            for (int k = 0; k < B; k++) begin
               if (e.shape) dut_sum[k] += int'(elem_a[k]) - int'(elem_b[k]);
               else         dut_sum[k] = 0;
               if (dut_sum[k] > worst)  worst = dut_sum[k];
               if (-dut_sum[k] > worst) worst = -dut_sum[k];
            end
            check("sum_s_bounded", (worst > 1) ? 1 : 0, 0);
            last = {e.a, e.b, e.sat};
         end
      end
   end

   initial begin : stimulus
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed corners: zero, full scale, overrange, mid code.
      drive(0, 1, 1);
      drive(30, 1, 1);
      drive(31, 1, 1);
      drive(20, 1, 1);
      // Single LSB toggling and all-layers-odd code.
      repeat (6) drive(1, 1, 1);
      repeat (6) drive(15, 1, 1);
      // Control events while streaming x = 1.
      repeat (2) drive(1, 1, 1);
      repeat (3) drive(1, 0, 1);
      repeat (2) drive(1, 1, 1);
      repeat (3) drive(1, 1, 0);
      repeat (3) drive(1, 1, 1);
      reset_pulse();
      repeat (4) drive(1, 1, 1);

      // Random stream.
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 31), ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 19) != 0));
      end

      repeat (3) drive(0, 0, 1);
      check("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/smsdac_seg_enc.md
# smsdac_seg_enc

Parametrised segmented mismatch-shaping DAC encoder, the successor to the fixed 8-element SMS DAC core. It converts a binary input code into 2·B unit-element drive bits arranged as B layers. Each layer is one element pair of weight 2^k. A first-order per-layer shaper chooses which element of a pair carries an odd layer count. This drives each pair's switching-sequence sum toward zero, first-order shaping element mismatch out of band. It sits between the digital modulator output and the pad-level element drivers.

## Interface
- B, default 4: number of weight layers, 1..16; full scale is 2·(2^B − 1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- x  input  B+1  unsigned input code; values above 2·(2^B − 1) saturate.
- en  input  1  sample/advance strobe; when low, all state and outputs hold.
- shape_en  input  1  1 = mismatch shaping active; 0 = static assignment.
- elem_a  output  B  element A drive per layer; bit k has weight 2^k.
- elem_b  output  B  element B drive per layer; bit k has weight 2^k.
- sat  output  1  registered flag: last sampled x was out of range.

## Operation
- Saturation: xs = min(x, 2·(2^B − 1)); sat = (x > max).
- Greedy layer split, from MSB down:
  - Start with r_{B−1} = xs.
  - At layer k, q = r_k >> k and c_k = min(q, 2).
  - Pass r_{k−1} = r_k − c_k·2^k to the next layer down.
  - Always Σ c_k·2^k = xs, with c_k ∈ {0, 1, 2}.
- Element drive per layer:
  - c_k = 0 → a = 0, b = 0.
  - c_k = 2 → a = 1, b = 1.
  - c_k = 1 → exactly one element is driven, per the shaper.
- Shaper per layer:
  - State acc_k is a 2-bit signed value in {−1, 0, +1}.
  - Switching sequence s_k = a_k − b_k.
  - acc_k > 0 → drive b (s = −1); acc_k < 0 → drive a (s = +1).
  - acc_k = 0 → drive a (s = +1), unless dither is compiled in (see Configuration).
  - On each en cycle, acc_k ← acc_k + s_k. The range is closed, so no saturation logic is needed.
- shape_en = 0: c_k = 1 always drives a, and every acc_k is cleared to 0 on that cycle.
- Output invariant: dac_v = Σ 2^k·(elem_a[k] + elem_b[k]) = xs of the sample.

## Timing
- x, shape_en and en are sampled on the rising edge of clk.
- elem_a, elem_b and sat are registered; latency is 1 cycle from the sampling edge.
- The accumulators update on the same edge as the outputs they correspond to.
- en = 0: outputs, acc_k and the LFSR all hold; x is ignored.
- shape_en toggling takes effect on the sample in which it is seen; there is no flush cycle.
- rst_n low, at any time including mid-stream: immediately forces elem_a = 0, elem_b = 0, sat = 0, all acc_k = 0 and LFSR = 16'hACE1.
- The first sample after reset release is treated as a fresh start (acc = 0).

## Configuration
- SMSDAC_DITHER_EN defined:
  - Adds a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing once per en cycle.
  - On an acc_k = 0 tie with c_k = 1, LFSR bit k selects the element: 1 → b, 0 → a.
  - This breaks idle tones.
- SMSDAC_DITHER_EN not defined:
  - There is no LFSR and ties always drive a.
  - Behaviour is fully deterministic.

## Structure
- Package smsdac_pkg holds:
  - the acc type (2-bit signed);
  - the LFSR width, taps and seed constants;
  - a function max_code(B).
- One sub-module, smsdac_layer:
  - inputs: residual, k, and the tie bit;
  - outputs: c_k, the a/b drive and the next residual;
  - contains the layer's acc register.
- The top generates B instances, chained MSB to LSB, plus the input saturation logic, output registers and optional LFSR.

## Test plan
All scenarios use B = 4, dither off unless noted.
- Reset, then x = 0 → elem_a = elem_b = 4'h0; then x = 30 → both = 4'hF, sat = 0.
- x = 31, then x = 20 → first sample sat = 1 with outputs equal to the x = 30 case; next sample sat = 0.
- x = 1 held for 6 en cycles → layer 0 sequence is a, b, a, b, a, b; Σs_0 stays in {0, 1}; dac_v = 1 every cycle.
- x = 15 held → every layer has c = 1, all layers alternate a/b in lockstep, dac_v = 15 throughout.
- Random x for 10k cycles, shape_en = 1:
  - dac_v equals xs one cycle later;
  - |Σs_k| ≤ 1 for every k;
  - with SMSDAC_DITHER_EN defined, the same checks hold and the tie choices match a reference LFSR.
- Control events during x = 1 streaming:
  - en low for 3 cycles → outputs frozen;
  - shape_en = 0 → elem_a[0] = 1 constant;
  - rst_n pulsed → outputs clear asynchronously and the sequence restarts with a.
